// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    localparam int unsigned MUL_CNT_W = 4;
    localparam logic [4:0]  REG_ZERO  = 5'd0;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MUL_WAIT = 2'd1,
        MEM_WAIT = 2'd2
    } hazard_state_e;

endpackage

// File: rtl/load_use_det.sv
// Load-use hazard detector: the load in EX writes a register the ID instruction reads.
module load_use_det
    import hazard_pkg::*;
(
    input  logic       ex_mem_read_i,
    input  logic [4:0] ex_rd_i,
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    output logic       load_use_o
);

    // x0 is hardwired zero, so a load targeting it never creates a dependency.
    always_comb begin
        load_use_o = ex_mem_read_i && (ex_rd_i != REG_ZERO) &&
                     ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, multi-cycle multiply hold, memory freeze
// and branch flush. Optional stall counter enabled by macro HAZARD_STALL_CNT_EN.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned MUL_LAT = 3
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [4:0] ID_rs1_i,
    input  logic [4:0] ID_rs2_i,
    input  logic       EX_MemRead_i,
    input  logic [4:0] EX_rd_i,
    input  logic       ID_branch_taken_i,
    input  logic       ID_mul_i,
    input  logic       mem_stall_i,
    output logic       PC_write_o,
    output logic       IF_IDWrite_o,
    output logic       IF_flush_o,
    output logic       ID_EX_hold_o,
    output logic       ID_EX_bubble_o,
    output logic       EX_MEM_bubble_o,
    output logic       back_hold_o
`ifdef HAZARD_STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt_o
`endif
);

    localparam bit MulEn = (MUL_LAT > 1);
    localparam logic [MUL_CNT_W-1:0] MulInit = MUL_CNT_W'(MUL_LAT - 1);

    hazard_state_e          state_q, state_d;
    hazard_state_e          resume_q, resume_d;
    hazard_state_e          eff_state;
    logic [MUL_CNT_W-1:0]   mul_cnt_q, mul_cnt_d;
    logic                   load_use;

    load_use_det u_load_use_det (
        .ex_mem_read_i (EX_MemRead_i),
        .ex_rd_i       (EX_rd_i),
        .id_rs1_i      (ID_rs1_i),
        .id_rs2_i      (ID_rs2_i),
        .load_use_o    (load_use)
    );

    // Next-state and Mealy outputs; an unfrozen MEM_WAIT cycle acts as the saved state.
    always_comb begin
        state_d         = state_q;
        resume_d        = resume_q;
        mul_cnt_d       = mul_cnt_q;
        PC_write_o      = 1'b0;
        IF_IDWrite_o    = 1'b0;
        IF_flush_o      = 1'b0;
        ID_EX_hold_o    = 1'b0;
        ID_EX_bubble_o  = 1'b0;
        EX_MEM_bubble_o = 1'b0;
        back_hold_o     = 1'b0;

        eff_state = state_q;
        if (state_q == MEM_WAIT && !mem_stall_i) begin
            eff_state = resume_q;
        end

        if (mem_stall_i) begin
            ID_EX_hold_o = 1'b1;
            back_hold_o  = 1'b1;
            if (state_q != MEM_WAIT) begin
                resume_d = state_q;
                state_d  = MEM_WAIT;
            end
        end else begin
            unique case (eff_state)
                RUN: begin
                    state_d = RUN;
                    if (load_use) begin
                        ID_EX_bubble_o = 1'b1;
                    end else begin
                        PC_write_o   = 1'b1;
                        IF_IDWrite_o = 1'b1;
                        IF_flush_o   = ID_branch_taken_i;
                        if (MulEn && ID_mul_i) begin
                            state_d   = MUL_WAIT;
                            mul_cnt_d = MulInit;
                        end
                    end
                end
                MUL_WAIT: begin
                    ID_EX_hold_o    = 1'b1;
                    EX_MEM_bubble_o = 1'b1;
                    mul_cnt_d       = mul_cnt_q - MUL_CNT_W'(1);
                    state_d         = (mul_cnt_q == MUL_CNT_W'(1)) ? RUN : MUL_WAIT;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end

        // Everything is quiet while reset is held, including the PC enable.
        if (!rst_i) begin
            PC_write_o      = 1'b0;
            IF_IDWrite_o    = 1'b0;
            IF_flush_o      = 1'b0;
            ID_EX_hold_o    = 1'b0;
            ID_EX_bubble_o  = 1'b0;
            EX_MEM_bubble_o = 1'b0;
            back_hold_o     = 1'b0;
        end
    end

    // Controller state registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= RUN;
            resume_q  <= RUN;
            mul_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            resume_q  <= resume_d;
            mul_cnt_q <= mul_cnt_d;
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Count cycles where the PC did not advance; wraps naturally.
    always_comb begin
        stall_cnt_d = PC_write_o ? stall_cnt_q : stall_cnt_q + 32'd1;
    end

    // Stall counter register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by random traffic,
// compared against a cycle-level behavioural model of the pipeline controls.
module tb_hazard_ctrl;

    localparam int unsigned MUL_LAT = 3;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic [4:0] ID_rs1_i = '0;
    logic [4:0] ID_rs2_i = '0;
    logic       EX_MemRead_i = 1'b0;
    logic [4:0] EX_rd_i = '0;
    logic       ID_branch_taken_i = 1'b0;
    logic       ID_mul_i = 1'b0;
    logic       mem_stall_i = 1'b0;
    logic       PC_write_o, IF_IDWrite_o, IF_flush_o, ID_EX_hold_o;
    logic       ID_EX_bubble_o, EX_MEM_bubble_o, back_hold_o;
`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_cnt_o;
`endif

    hazard_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .ID_rs1_i          (ID_rs1_i),
        .ID_rs2_i          (ID_rs2_i),
        .EX_MemRead_i      (EX_MemRead_i),
        .EX_rd_i           (EX_rd_i),
        .ID_branch_taken_i (ID_branch_taken_i),
        .ID_mul_i          (ID_mul_i),
        .mem_stall_i       (mem_stall_i),
        .PC_write_o        (PC_write_o),
        .IF_IDWrite_o      (IF_IDWrite_o),
        .IF_flush_o        (IF_flush_o),
        .ID_EX_hold_o      (ID_EX_hold_o),
        .ID_EX_bubble_o    (ID_EX_bubble_o),
        .EX_MEM_bubble_o   (EX_MEM_bubble_o),
        .back_hold_o       (back_hold_o)
`ifdef HAZARD_STALL_CNT_EN
        ,
        .stall_cnt_o       (stall_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: cycles of multiply occupancy left; a freeze simply pauses time.
    int          mul_left = 0;
    logic [31:0] stall_cnt_m = '0;

    // Output vector order: {PC, IF_ID, flush, ID_EX hold, ID_EX bubble, EX_MEM bubble, back hold}
    task automatic step(input logic [4:0] rs1, input logic [4:0] rs2, input logic mr,
                        input logic [4:0] rd, input logic br, input logic mul,
                        input logic stall, input logic rst, input string tag);
        logic       lu;
        logic [6:0] exp_v;
        logic [6:0] got_v;
        @(negedge clk_i);
        ID_rs1_i = rs1; ID_rs2_i = rs2; EX_MemRead_i = mr; EX_rd_i = rd;
        ID_branch_taken_i = br; ID_mul_i = mul; mem_stall_i = stall; rst_i = rst;
        #1;
        lu = mr && (rd != 5'd0) && (rd == rs1 || rd == rs2);
        if (!rst) begin
            mul_left    = 0;
            stall_cnt_m = '0;
            exp_v       = 7'b0000000;
        end else if (stall) begin
            exp_v = 7'b0001001;
        end else if (mul_left > 0) begin
            exp_v = 7'b0001010;
        end else if (lu) begin
            exp_v = 7'b0000100;
        end else begin
            exp_v = {2'b11, br, 4'b0000};
        end
        got_v = {PC_write_o, IF_IDWrite_o, IF_flush_o, ID_EX_hold_o, ID_EX_bubble_o,
                 EX_MEM_bubble_o, back_hold_o};
        n_checks++;
        assert (got_v === exp_v) else begin
            n_fail++;
            $error("FAIL %s: outputs observed %b expected %b", tag, got_v, exp_v);
        end
`ifdef HAZARD_STALL_CNT_EN
        n_checks++;
        assert (stall_cnt_o === stall_cnt_m) else begin
            n_fail++;
            $error("FAIL %s stall_cnt: observed %0d expected %0d", tag, stall_cnt_o,
                   stall_cnt_m);
        end
`endif
        @(posedge clk_i);
        if (rst) begin
            if (!exp_v[6]) stall_cnt_m = stall_cnt_m + 32'd1;
            if (!stall) begin
                if (mul_left > 0) mul_left--;
                else if (mul && !lu && MUL_LAT > 1) mul_left = MUL_LAT - 1;
            end
        end
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, tag);
    endtask

    initial begin
        // Reset state, including PC_write forced low.
        step(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, "reset");
        step(5'd5, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, "reset_busy_inputs");
        idle(2, "run_idle");

        // Load-use on rs2: one bubble, then running again.
        step(5'd3, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, "load_use");
        idle(1, "load_use_after");

        // x0 destination never stalls.
        step(5'd0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, "x0_exclusion");

        // Multiply: two MUL_WAIT cycles then RUN.
        step(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, "mul_issue");
        idle(2, "mul_wait");
        idle(1, "mul_done");

        // Multiply with a 4-cycle freeze after its first wait cycle.
        step(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, "mul2_issue");
        idle(1, "mul2_wait1");
        for (int i = 0; i < 4; i++)
            step(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, "mul2_freeze");
        idle(1, "mul2_wait_last");
        idle(1, "mul2_done");

        // Freeze landing on the multiply-issue cycle defers the multiply.
        step(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, "mul_under_freeze");

        // Branch with load-use: flush deferred a cycle.
        step(5'd4, 5'd1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1, "branch_load_use");
        step(5'd4, 5'd1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1, "branch_retry");

        // Branch during freeze: flush only on release.
        step(5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, "branch_freeze1");
        step(5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, "branch_freeze2");
        step(5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, "branch_release");
        idle(1, "branch_after");

        // Reset in the middle of a multiply abandons it.
        step(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, "mul3_issue");
        step(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, "reset_mid_mul");
        idle(1, "after_reset_run");

        // Randomized traffic over a small register range to provoke hazards.
        for (int i = 0; i < 600; i++) begin
            step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 4) == 0),
                 1'($urandom_range(0, 6) == 0), 1'($urandom_range(0, 60) != 0), "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
